shift_rx_nbit: RTL and testbench

Serial-to-parallel receiver for the n-bit shift-register datapath. It takes one bit per accepted cycle from a serial stream produced by a left- or right-shifting source and assembles n-bit words. Each completed word goes to a holding register and is offered downstream with a valid/ready handshake. It sits at the far end of the serial `ls`/`rs` link, turning the shifted bit stream back into parallel words.

---
 rtl/shift_rx_nbit_if.sv | 34 +++
 rtl/shift_rx_nbit.sv | 113 +++++++++++
 tb/tb_shift_rx_nbit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_rx_nbit_if.sv
// shift_rx_nbit_if
// Groups the serial-input and parallel-output handshake of the n-bit
// serial-to-parallel receiver.
//   bit_in, bit_valid, dir, abort : serial stream in (driven by master)
//   word_ready                    : downstream accept (driven by master)
//   word_out, word_valid          : holding register out (driven by slave)
//   busy, bit_cnt, overrun        : status (driven by slave)
// The receiver is the slave; the stream source/word sink is the master.
interface shift_rx_nbit_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic          bit_in;
  logic          bit_valid;
  logic          dir;
  logic          abort;
  logic          word_ready;
  logic [N-1:0]  word_out;
  logic          word_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;

  modport master (
    output bit_in, bit_valid, dir, abort, word_ready,
    input  word_out, word_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  bit_in, bit_valid, dir, abort, word_ready,
    output word_out, word_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/shift_rx_nbit.sv
// shift_rx_nbit
// Serial-to-parallel receiver: assembles n-bit words from a bit stream that
// arrives MSB first (dir=0, left-shift source) or LSB first (dir=1,
// right-shift source), then offers each word downstream via valid/ready.
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset, overrides everything
//   bus : shift_rx_nbit_if slave (serial in, word out, status)
// The interface instance must be built with N equal to this module's n.
module shift_rx_nbit #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           clr,
  shift_rx_nbit_if.slave bus
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          dir_q, dir_d;
  logic [n-1:0]  word_out_q, word_out_d;
  logic          word_valid_q, word_valid_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          last;
  logic          dir_eff;
  logic [n-1:0]  shifted;

  // A bit is taken only when no abort is pending.
  assign accept  = bus.bit_valid & ~bus.abort;
  assign last    = accept && (bit_cnt_q == CW'(n - 1));
  // The first bit of a word already follows the live dir input; later bits
  // use the direction latched with that first bit.
  assign dir_eff = (state_q == IDLE) ? bus.dir : dir_q;
  assign shifted = dir_eff ? {bus.bit_in, sreg_q[n-1:1]}
                           : {sreg_q[n-2:0], bus.bit_in};

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    dir_d        = dir_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    // Assembly path
    if (bus.abort) begin
      sreg_d    = '0;
      bit_cnt_d = '0;
    end else if (bus.bit_valid) begin
      sreg_d = shifted;
      if (state_q == IDLE) begin
        dir_d = bus.dir;
      end
      if (last) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // Holding register: a completing word may replace a word that is being
    // consumed on the same edge; otherwise a full holder drops it.
    if (last) begin
      if (!word_valid_q || bus.word_ready) begin
        word_out_d   = shifted;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (word_valid_q && bus.word_ready) begin
      word_valid_d = 1'b0;
    end

    state_d = (bit_cnt_d != '0) ? ASSEMBLE : IDLE;
    busy_d  = (bit_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      dir_q        <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      dir_q        <= dir_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.busy       = busy_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_shift_rx_nbit.sv
// tb_shift_rx_nbit
// Directed scenarios plus a randomized run of shift_rx_nbit (n=4), checked
// against a word-level reference model kept in the bench.
module tb_shift_rx_nbit;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  shift_rx_nbit_if #(.N(N)) bus ();

  shift_rx_nbit #(.n(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: bits collected for the current word, in arrival order.
  logic         m_bits [N];
  int           m_cnt;
  logic         m_dir;
  logic [N-1:0] m_word;
  logic         m_valid;
  logic         m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_dir   = 1'b0;
    m_word  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic cyc(input logic b, input logic v, input logic d,
                     input logic a, input logic r, input logic c);
    logic         done;
    logic [N-1:0] w;
    bus.bit_in     = b;
    bus.bit_valid  = v;
    bus.dir        = d;
    bus.abort      = a;
    bus.word_ready = r;
    clr            = c;
    @(posedge clk);
    done = 1'b0;
    w    = '0;
    if (c) begin
      model_reset();
    end else begin
      if (a) begin
        m_cnt = 0;
      end else if (v) begin
        if (m_cnt == 0) m_dir = d;
        m_bits[m_cnt] = b;
        m_cnt++;
        if (m_cnt == N) begin
          // MSB-first: first bit is the top bit; LSB-first: first bit is bit 0.
          for (int i = 0; i < N; i++) begin
            if (m_dir) w[i] = m_bits[i];
            else       w[N-1-i] = m_bits[i];
          end
          m_cnt = 0;
          done  = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || r) begin
          m_word  = w;
          m_valid = 1'b1;
          $display("word %b accepted into holding register", w);
        end else begin
          m_ovr = 1'b1;
          $display("word %b dropped (holder full)", w);
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("word_out",   32'(bus.word_out),   32'(m_word));
    check("word_valid", 32'(bus.word_valid), 32'(m_valid));
    check("busy",       32'(bus.busy),       32'(m_cnt != 0));
    check("bit_cnt",    32'(bus.bit_cnt),    32'(m_cnt));
    check("overrun",    32'(bus.overrun),    32'(m_ovr));
  endtask

  // Send a 4-bit pattern MSB-first in time (p[3] first) with fixed dir/ready.
  task automatic send4(input logic [3:0] p, input logic d, input logic r);
    for (int i = 3; i >= 0; i--) cyc(p[i], 1'b1, d, 1'b0, r, 1'b0);
  endtask

  task automatic do_clr();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] p;
    model_reset();
    bus.bit_in = 0; bus.bit_valid = 0; bus.dir = 0; bus.abort = 0; bus.word_ready = 0;
    clr = 1'b1;
    do_clr();
    do_clr();

    // Reset mid-word
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_clr();
    check("rst_word",  32'(bus.word_out),   32'h0);
    check("rst_valid", 32'(bus.word_valid), 32'h0);
    check("rst_busy",  32'(bus.busy),       32'h0);
    check("rst_cnt",   32'(bus.bit_cnt),    32'h0);
    check("rst_ovr",   32'(bus.overrun),    32'h0);
    send4(4'b1111, 1'b0, 1'b0);
    check("rst_next_word", 32'(bus.word_out), 32'hF);

    // MSB-first with busy profile
    do_clr();
    p = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      cyc(p[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("msb_busy", 32'(bus.busy), (i == 0) ? 32'h0 : 32'h1);
    end
    check("msb_word",  32'(bus.word_out),   32'hB);
    check("msb_valid", 32'(bus.word_valid), 32'h1);

    // LSB-first with dir toggled mid-word
    do_clr();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lsb_word", 32'(bus.word_out), 32'hD);

    // Back-to-back with ready held
    do_clr();
    send4(4'b1111, 1'b0, 1'b1);
    check("b2b_word1", 32'(bus.word_out), 32'hF);
    send4(4'b0001, 1'b0, 1'b1);
    check("b2b_word2", 32'(bus.word_out),   32'h1);
    check("b2b_valid", 32'(bus.word_valid), 32'h1);
    check("b2b_ovr",   32'(bus.overrun),    32'h0);

    // Overrun
    do_clr();
    send4(4'b1010, 1'b0, 1'b0);
    send4(4'b0110, 1'b0, 1'b0);
    check("ovr_word", 32'(bus.word_out), 32'hA);
    check("ovr_flag", 32'(bus.overrun),  32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_consumed", 32'(bus.word_valid), 32'h0);
    check("ovr_sticky",   32'(bus.overrun),    32'h1);
    do_clr();
    check("ovr_cleared",  32'(bus.overrun),    32'h0);

    // Abort, then completion coinciding with consumption
    send4(4'b0011, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_cnt", 32'(bus.bit_cnt), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("swap_word",  32'(bus.word_out),   32'hC);
    check("swap_valid", 32'(bus.word_valid), 32'h1);
    check("swap_ovr",   32'(bus.overrun),    32'h0);

    // Randomized run against the model
    do_clr();
    for (int k = 0; k < 2000; k++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
